// File: rtl/pipelined_addsub_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_addsub_pkg
//   Shared definitions for the pipelined add/subtract unit:
//     - stage_ctrl_t   : per-stage control bundle {vld, sub}
//     - chunk_width()  : slice width (WIDTH / STAGES)
//     - params_legal() : parameter legality check used at elaboration
// ---------------------------------------------------------------------------
package pipelined_addsub_pkg;

    // Control travelling alongside each operation through the pipeline.
    typedef struct packed {
        logic vld;   // stage holds a live operation (0 = bubble)
        logic sub;   // operation mode captured at issue
    } stage_ctrl_t;

    // Bits handled by one pipeline slice.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    // WIDTH must split evenly into 1..WIDTH slices.
    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// ---------------------------------------------------------------------------
// addsub_slice
//   Combinational W-bit adder slice with carry in/out. The caller supplies the
//   B operand already inverted for subtraction.
//   Ports:
//     a_i [W-1:0]  operand A slice
//     b_i [W-1:0]  operand B slice (possibly inverted)
//     c_i          carry into the slice
//     s_o [W-1:0]  sum slice
//     c_o          carry out of the slice
// ---------------------------------------------------------------------------
module addsub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/pipelined_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_addsub
//   WIDTH-bit add/subtract split into STAGES equal slices. Each slice adds its
//   chunk and the result is registered together with the carry, the operands
//   still to be added, the sum bits already produced and the control bundle.
//   Latency is STAGES cycles, throughput one operation per cycle.
//
//   Optional feature macro: PIPELINED_ADDSUB_OVF_EN adds the ovf port (signed
//   overflow, aligned with sum/out_valid).
//
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     in_valid/in_ready  input handshake
//     a, b [WIDTH-1:0]   operands
//     cin                carry-in (add only)
//     sub                0: a+b+cin, 1: a-b
//     out_valid/out_ready output handshake
//     sum [WIDTH:0]      result, sum[WIDTH] = carry out (sub: 1 = no borrow)
//     ovf                signed overflow (PIPELINED_ADDSUB_OVF_EN only)
//
//   Handshake: a transfer happens on a rising edge where valid && ready. The
//   whole pipeline advances together when en = !out_valid || out_ready, and
//   in_ready equals en, so a full pipeline can pop and push in the same cycle.
//   While out_valid && !out_ready, sum/out_valid hold and in_ready is 0.
// ---------------------------------------------------------------------------
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
`ifdef PIPELINED_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $fatal(1, "pipelined_addsub: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    // Stage registers
    stage_ctrl_t      ctrl_q [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] s_q    [STAGES];
    logic             c_q    [STAGES];

    // Values loaded into each stage register on an enabled edge
    stage_ctrl_t      ctrl_d [STAGES];
    logic [WIDTH-1:0] a_d    [STAGES];
    logic [WIDTH-1:0] b_d    [STAGES];
    logic [WIDTH-1:0] s_prev [STAGES];  // sum bits produced by earlier slices
    logic             ci     [STAGES];  // carry into this stage's slice
    logic [WIDTH-1:0] s_d    [STAGES];
    logic             c_d    [STAGES];

    logic en;

    assign en        = !ctrl_q[STAGES-1].vld || out_ready;
    assign in_ready  = en;
    assign out_valid = ctrl_q[STAGES-1].vld;
    assign sum       = {c_q[STAGES-1], s_q[STAGES-1]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] b_chunk;
        logic [CHUNK-1:0] s_chunk;
        logic             co;

        if (k == 0) begin : g_head
            assign ctrl_d[k] = '{vld: in_valid, sub: sub};
            assign a_d[k]    = a;
            assign b_d[k]    = b;
            assign s_prev[k] = '0;
            // Subtraction is a + ~b + 1; cin only matters for addition.
            assign ci[k]     = sub ? 1'b1 : cin;
        end else begin : g_body
            assign ctrl_d[k] = ctrl_q[k-1];
            assign a_d[k]    = a_q[k-1];
            assign b_d[k]    = b_q[k-1];
            assign s_prev[k] = s_q[k-1];
            assign ci[k]     = c_q[k-1];
        end

        assign b_chunk = ctrl_d[k].sub ? ~b_d[k][k*CHUNK +: CHUNK]
                                       :  b_d[k][k*CHUNK +: CHUNK];

        addsub_slice #(.W(CHUNK)) u_slice (
            .a_i (a_d[k][k*CHUNK +: CHUNK]),
            .b_i (b_chunk),
            .c_i (ci[k]),
            .s_o (s_chunk),
            .c_o (co)
        );

        // Bits at and above this chunk are still zero in s_prev, so OR merges.
        assign s_d[k] = s_prev[k] | (WIDTH'(s_chunk) << (k*CHUNK));
        assign c_d[k] = co;
    end

    // Data registers load only for live operations, so bubbles leave the
    // previous contents (zero after reset) in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                s_q[k]    <= '0;
                c_q[k]    <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_d[k];
                if (ctrl_d[k].vld) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
        end
    end

`ifdef PIPELINED_ADDSUB_OVF_EN
    logic ovf_q;
    logic ovf_d;
    logic msb_b;

    assign msb_b = ctrl_d[STAGES-1].sub ? ~b_d[STAGES-1][WIDTH-1] : b_d[STAGES-1][WIDTH-1];
    // Carry into the MSB is recovered from the MSB sum bit: s ^ a ^ b'.
    assign ovf_d = (s_d[STAGES-1][WIDTH-1] ^ a_d[STAGES-1][WIDTH-1] ^ msb_b) ^ c_d[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en && ctrl_d[STAGES-1].vld) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

    localparam int W    = 16;
    localparam int NDUT = 3;   // 0: STAGES=4, 1: STAGES=1, 2: STAGES=16

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W:0]   exp_sum;
        logic         exp_ovf;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         or_m;
    logic         in_ready_w  [NDUT];
    logic         out_valid_w [NDUT];
    logic [W:0]   sum_w       [NDUT];
`ifdef PIPELINED_ADDSUB_OVF_EN
    logic         ovf_w       [NDUT];
`endif

    pipelined_addsub #(.WIDTH(W), .STAGES(4)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid_w[0]), .out_ready(or_m), .sum(sum_w[0])
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(ovf_w[0])
`endif
    );

    pipelined_addsub #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid_w[1]), .out_ready(1'b1), .sum(sum_w[1])
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(ovf_w[1])
`endif
    );

    pipelined_addsub #(.WIDTH(W), .STAGES(16)) u_s16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid_w[2]), .out_ready(1'b1), .sum(sum_w[2])
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(ovf_w[2])
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int lat_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic logic [W:0] model_sum(input logic [W-1:0] va, input logic [W-1:0] vb,
                                             input logic vcin, input logic vsub);
        int r;
        if (vsub) r = int'(va) - int'(vb) + (1 << W);
        else      r = int'(va) + int'(vb) + int'(vcin);
        return r[W:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] va, input logic [W-1:0] vb,
                                       input logic vcin, input logic vsub);
        int sa;
        int sb;
        int r;
        sa = int'($signed(va));
        sb = int'($signed(vb));
        r  = vsub ? (sa - sb) : (sa + sb + int'(vcin));
        return (r > 32767) || (r < -32768);
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [W:0] exp_q     [NDUT][$];
    logic       exp_ovf_q [NDUT][$];
    int         cyc_q     [NDUT][$];
    bit         lat_on = 1'b1;
    bit         prev_stall = 1'b0;
    logic [W:0] prev_sum;
    logic       mon_ordy;
    logic [W:0] mon_e;
    logic       mon_eo;
    int         mon_c;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDUT; i++) begin
                exp_q[i].delete();
                exp_ovf_q[i].delete();
                cyc_q[i].delete();
            end
            prev_stall = 1'b0;
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                mon_ordy = (i == 0) ? or_m : 1'b1;
                if (out_valid_w[i] && mon_ordy) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_out_dut%0d", i), 1'b0, sum_w[i], 0);
                    end else begin
                        mon_e  = exp_q[i].pop_front();
                        mon_eo = exp_ovf_q[i].pop_front();
                        mon_c  = cyc_q[i].pop_front();
                        check($sformatf("sum_dut%0d", i), sum_w[i] == mon_e, sum_w[i], mon_e);
`ifdef PIPELINED_ADDSUB_OVF_EN
                        check($sformatf("ovf_dut%0d", i), ovf_w[i] == mon_eo, ovf_w[i], mon_eo);
`endif
                        if (i != 0 || lat_on)
                            check($sformatf("latency_dut%0d", i), (cyc - mon_c) == lat_of(i),
                                  cyc - mon_c, lat_of(i));
                    end
                end
                if (in_valid && in_ready_w[i]) begin
                    exp_q[i].push_back(model_sum(a, b, cin, sub));
                    exp_ovf_q[i].push_back(model_ovf(a, b, cin, sub));
                    cyc_q[i].push_back(cyc);
                end
            end
            // Ready may only drop while a result waits for downstream.
            check("in_ready_rule", in_ready_w[0] == (!out_valid_w[0] || or_m),
                  in_ready_w[0], !out_valid_w[0] || or_m);
            if (prev_stall)
                check("stall_hold", out_valid_w[0] && (sum_w[0] == prev_sum),
                      {out_valid_w[0], sum_w[0]}, {1'b1, prev_sum});
            prev_stall = out_valid_w[0] && !or_m;
            prev_sum   = sum_w[0];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op to an empty, flowing pipeline and check it on the main DUT.
    task automatic issue_and_wait(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                                  input logic vcin, input logic vsub,
                                  input logic [W:0] es, input logic eo);
        bit seen;
        int t_seen;
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        t_seen = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (out_valid_w[0]) begin
                seen = 1'b1;
                t_seen = t;
                break;
            end
        end
        check({name, "_seen"}, seen, seen, 1);
        if (seen) begin
            check({name, "_latency"}, t_seen == 3, t_seen, 3);
            check({name, "_sum"}, sum_w[0] == es, sum_w[0], es);
`ifdef PIPELINED_ADDSUB_OVF_EN
            check({name, "_ovf"}, ovf_w[0] == eo, ovf_w[0], eo);
`endif
            @(negedge clk);
            check({name, "_one_pulse"}, out_valid_w[0] == 1'b0, out_valid_w[0], 0);
        end
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, actual timeout required finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    vec_t vecs [8];
    int   sent;
    int   guard;
    bit   xfer;
    bit   saw_block;

    initial begin
        vecs[0] = '{a: 16'h00FF, b: 16'h0001, cin: 1'b0, sub: 1'b0, exp_sum: 17'h00100, exp_ovf: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sub: 1'b0, exp_sum: 17'h10000, exp_ovf: 1'b0};
        vecs[2] = '{a: 16'h0005, b: 16'h0007, cin: 1'b1, sub: 1'b1, exp_sum: 17'h0FFFE, exp_ovf: 1'b0};
        vecs[3] = '{a: 16'h8000, b: 16'h0001, cin: 1'b0, sub: 1'b1, exp_sum: 17'h17FFF, exp_ovf: 1'b1};
        vecs[4] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, exp_sum: 17'h08000, exp_ovf: 1'b1};
        vecs[5] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, sub: 1'b1, exp_sum: 17'h10000, exp_ovf: 1'b0};
        vecs[6] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sub: 1'b0, exp_sum: 17'h1FFFF, exp_ovf: 1'b0};
        vecs[7] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sub: 1'b0, exp_sum: 17'h05555, exp_ovf: 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; or_m = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_out_valid_dut%0d", i), out_valid_w[i] == 1'b0, out_valid_w[i], 0);
            check($sformatf("rst_sum_dut%0d", i), sum_w[i] == '0, sum_w[i], 0);
            check($sformatf("rst_in_ready_dut%0d", i), in_ready_w[i] == 1'b1, in_ready_w[i], 1);
`ifdef PIPELINED_ADDSUB_OVF_EN
            check($sformatf("rst_ovf_dut%0d", i), ovf_w[i] == 1'b0, ovf_w[i], 0);
`endif
        end
        tick();

        // Directed vectors
        for (int i = 0; i < 8; i++)
            issue_and_wait($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                           vecs[i].exp_sum, vecs[i].exp_ovf);

        // Back-pressure: 8 ops, out_ready low for 5 cycles mid-stream
        lat_on = 1'b0;
        sent = 0; guard = 0; xfer = 1'b1; saw_block = 1'b0;
        while (sent < 8 && guard < 200) begin
            if (xfer) begin
                a = W'($urandom_range(0, 65535)); b = W'($urandom_range(0, 65535));
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            or_m = (guard < 4 || guard >= 9);
            @(negedge clk);
            xfer = in_ready_w[0];
            if (!in_ready_w[0]) saw_block = 1'b1;
            if (xfer) sent++;
            tick();
            guard++;
        end
        in_valid = 1'b0; or_m = 1'b1;
        check("bp_all_sent", sent == 8, sent, 8);
        check("bp_in_ready_dropped", saw_block, saw_block, 1);
        repeat (25) tick();
        lat_on = 1'b1;

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom_range(0, 65535)); b = W'($urandom_range(0, 65535));
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_flush_out_valid", out_valid_w[0] == 1'b0, out_valid_w[0], 0);
            check("rst_flush_sum", sum_w[0] == '0, sum_w[0], 0);
            check("rst_flush_in_ready", in_ready_w[0] == 1'b1, in_ready_w[0], 1);
        end
        tick();
        issue_and_wait("post_rst", 16'hA5A5, 16'h5A5B, 1'b0, 1'b1,
                       model_sum(16'hA5A5, 16'h5A5B, 1'b0, 1'b1),
                       model_ovf(16'hA5A5, 16'h5A5B, 1'b0, 1'b1));

        // Random mixed stream with random back-pressure and bubbles
        lat_on = 1'b0;
        xfer = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || xfer) begin
                a = W'($urandom_range(0, 65535)); b = W'($urandom_range(0, 65535));
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            or_m = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            xfer = in_valid && in_ready_w[0];
            tick();
        end
        in_valid = 1'b0; or_m = 1'b1;
        repeat (30) tick();

        for (int i = 0; i < NDUT; i++)
            check($sformatf("drained_dut%0d", i), exp_q[i].size() == 0, exp_q[i].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
